datapath_trace_checker: RTL and testbench
=========================================

# datapath_trace_checker

Parametrised, synthesizable self-checking monitor for the single-cycle datapath. It captures up to NUM_CH observed buses each clock, such as register write-data, PC result, Hi and Lo. Each capture is compared against a preloaded expected-trace memory. The block counts mismatches, records the first failure, and detects a stalled PC (halt loop). It sits beside the Datapath in the top-level bench/FPGA wrapper and replaces eyeballing of waveforms with a Done/Pass verdict.

## Interface
- WIDTH, 32, bit width of each observed channel
- NUM_CH, 4, number of observed channels (ch0 = write-data, ch1 = PC, ch2 = Hi, ch3 = Lo by convention)
- DEPTH, 256, expected-trace entries; AW = $clog2(DEPTH)
- PC_CH, 1, channel index used for halt detection
- HALT_CYCLES, 8, consecutive unchanged-PC samples that declare a halt (≥2)
- Clk  input  1  clock; all logic rising-edge
- Rst  input  1  synchronous, active-high reset
- Start  input  1  begin/restart a check run
- Trace_len  input  AW+1  number of entries to check, 0..DEPTH; values >DEPTH clamp to DEPTH
- Exp_we  input  1  write expected entry (honoured only in IDLE)
- Exp_addr  input  AW  expected-entry address
- Exp_data  input  NUM_CH*WIDTH  expected entry; ch i at bits [i*WIDTH +: WIDTH]
- Exp_mask  input  NUM_CH  per-channel compare enable (present only with TRACE_MASK_EN)
- Obs_valid  input  1  Obs_data is a valid sample this cycle
- Obs_data  input  NUM_CH*WIDTH  observed buses, same packing as Exp_data
- Busy  output  1  run in progress
- Done  output  1  run finished (sticky until Start/Rst)
- Pass  output  1  valid only while Done
- Halt_detected  output  1  run ended by PC stall
- Mismatch_count  output  16  mismatched entries, saturating at 16'hFFFF
- First_fail_idx  output  AW  entry index of first mismatch
- First_fail_ch  output  $clog2(NUM_CH) (min 1)  lowest mismatching channel of that entry

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0, idx 0, stall counter 0. The expected memory is not cleared by Rst.
- IDLE: Exp_we writes mem[Exp_addr] ← Exp_data (and mask). On Start: if clamped Trace_len==0, go to DONE with Pass=1; otherwise go to RUN with idx, count, first-fail and stall counter cleared.
- RUN: memory read is asynchronous at idx. On each cycle with Obs_valid=1, compare every channel of Obs_data to mem[idx].
  - An entry mismatches if any channel differs.
  - On a mismatch: count += 1 (saturating).
  - On the first mismatch of the run: latch idx and the lowest differing channel.
  - idx then increments.
- Obs_valid=0 in RUN: nothing changes, including the stall counter.
- Halt: on a valid sample whose PC_CH value equals the previous valid sample's PC, stall counter += 1; otherwise reset it to 0.
  - When the counter reaches HALT_CYCLES−1 (i.e. HALT_CYCLES identical samples), go to DONE with Halt_detected=1.
  - That sample is still compared and counted.
- End of trace: the valid sample at idx==Trace_len−1 → DONE.
  - If the halt condition fires on the same sample, both Done and Halt_detected are set.
- Pass = (Mismatch_count==0) && (entries compared == Trace_len).
  - An early halt therefore fails unless halt coincides with the last entry.
- DONE: Done=1, Busy=0, and all results hold. Start → RUN (restart, results cleared). Exp_we is ignored outside IDLE. To reload the memory, assert Rst first.
- Start while in RUN restarts the run (idx=0, results cleared).

## Timing
- Start sampled at edge k → Busy=1 after edge k; the first comparable sample is the one presented before edge k+1.
- Compare latency: a sample presented before edge n updates Mismatch_count/First_fail_* after edge n.
- Done asserts after the same edge as the last compare; the count then includes that entry.
- Exp_we write takes effect at the edge; reading that address in the following cycle returns the new data.
- Rst mid-run: the next edge forces IDLE and zeroes outputs; Rst dominates Start.

## Configuration
- TRACE_MASK_EN defined: the memory stores NUM_CH mask bits per entry, and the Exp_mask port exists.
  - A channel with mask bit 0 is don't-care: it never mismatches and is never reported in First_fail_ch.
  - The halt check uses raw Obs_data regardless of mask.
- Undefined: no mask storage or port; all channels are always compared.

## Test plan
- Load 4 entries with PC = 0,4,8,12 (other channels 0); Trace_len=4; drive matching samples → Done after 4th sample, Pass=1, Mismatch_count=0, Halt_detected=0.
- Same trace, corrupt ch2 of entry 2 (Hi=0x5 vs 0x0) and ch0 of entry 3 → Mismatch_count=2, First_fail_idx=2, First_fail_ch=2, Pass=0.
- Trace_len=20; PC held at 0x20 from sample 3 onward with matching data, HALT_CYCLES=8 → Done and Halt_detected after sample 10, Pass=0.
- Obs_valid toggled 1,0,0,1 with identical PC → stall counter counts only the 2 valid samples; no halt, and idx advances by 2.
- Assert Rst during RUN at entry 5 → next cycle all outputs 0 and state IDLE. Then Start without reloading → the same memory contents are checked again and Pass=1.
- TRACE_MASK_EN: entry 1 mask=4'b1101 with ch1 mismatching → Pass=1; mask=4'b1111 → First_fail_ch=1.

Source files
------------

// File: rtl/datapath_trace_checker.sv
// datapath_trace_checker: compares observed datapath buses against a
// preloaded expected trace, counts mismatches, records the first failure
// and ends a run early when the PC stalls (halt loop).
//
// Build option: define TRACE_MASK_EN to add per-channel compare masks.
// The mask is stored with each entry and loaded through the Exp_mask port.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   Start, Trace_len    begin or restart a run over Trace_len entries
//   Exp_we/addr/data    expected-trace load port (used only in IDLE)
//   Exp_mask            per-channel compare enable (TRACE_MASK_EN only)
//   Obs_valid/Obs_data  observed sample, channel i at [i*WIDTH +: WIDTH]
//   Busy, Done, Pass    run status and verdict
//   Halt_detected       run ended on a stalled PC
//   Mismatch_count      saturating count of mismatching entries
//   First_fail_idx/ch   entry and lowest channel of the first mismatch
module datapath_trace_checker #(
   parameter int WIDTH       = 32,
   parameter int NUM_CH      = 4,
   parameter int DEPTH       = 256,
   parameter int PC_CH       = 1,
   parameter int HALT_CYCLES = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Start,
   input  logic [AW:0]             Trace_len,
   input  logic                    Exp_we,
   input  logic [AW-1:0]           Exp_addr,
   input  logic [NUM_CH*WIDTH-1:0] Exp_data,
`ifdef TRACE_MASK_EN
   input  logic [NUM_CH-1:0]       Exp_mask,
`endif
   input  logic                    Obs_valid,
   input  logic [NUM_CH*WIDTH-1:0] Obs_data,
   output logic                    Busy,
   output logic                    Done,
   output logic                    Pass,
   output logic                    Halt_detected,
   output logic [15:0]             Mismatch_count,
   output logic [AW-1:0]           First_fail_idx,
   output logic [CW-1:0]           First_fail_ch
);

   localparam int SW = $clog2(HALT_CYCLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   logic [NUM_CH*WIDTH-1:0] mem [DEPTH];
`ifdef TRACE_MASK_EN
   logic [NUM_CH-1:0]       mask_mem [DEPTH];
`endif

   logic [AW:0]       len_c;
   logic [AW:0]       len_r;
   logic [AW:0]       n_cmp;
   logic [AW:0]       cmp_nxt;
   logic [SW-1:0]     stall;
   logic [SW-1:0]     stall_nxt;
   logic [WIDTH-1:0]  prev_pc;
   logic [WIDTH-1:0]  pc;
   logic              have_prev;
   logic              have_fail;
   logic              pass_r;
   logic [NUM_CH*WIDTH-1:0] exp_row;
   logic [NUM_CH-1:0] diff;
   logic [CW-1:0]     fch;
   logic              mism;
   logic              last;
   logic              halt_fire;
   logic              sample_ev;

   // Lengths beyond the memory size clamp to a full-memory run.
   assign len_c = (Trace_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : Trace_len;

   assign exp_row = mem[n_cmp[AW-1:0]];
   assign pc      = Obs_data[PC_CH*WIDTH +: WIDTH];

   always_comb begin
      diff = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         diff[i] = Obs_data[i*WIDTH +: WIDTH] != exp_row[i*WIDTH +: WIDTH];
      end
`ifdef TRACE_MASK_EN
      diff = diff & mask_mem[n_cmp[AW-1:0]];
`endif
      // Scan downward so the lowest differing channel wins.
      fch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (diff[i]) fch = CW'(i);
      end
   end

   assign mism      = |diff;
   assign stall_nxt = (have_prev && pc == prev_pc) ? stall + 1'b1 : '0;
   assign halt_fire = stall_nxt == SW'(HALT_CYCLES - 1);
   assign cmp_nxt   = n_cmp + 1'b1;
   assign last      = cmp_nxt == len_r;
   assign sample_ev = (state == RUN) && Obs_valid && !Start;

   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (Start) state_nxt = (len_c == '0) ? DONE : RUN;
         end
         RUN: begin
            if (Start)
               state_nxt = (len_c == '0) ? DONE : RUN;
            else if (Obs_valid && (last || halt_fire))
               state_nxt = DONE;
         end
         DONE: begin
            if (Start) state_nxt = (len_c == '0) ? DONE : RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Trace memory has no reset: it survives Rst so a run can be repeated.
   always_ff @(posedge Clk) begin
      if (Exp_we && state == IDLE) begin
         mem[Exp_addr] <= Exp_data;
`ifdef TRACE_MASK_EN
         mask_mem[Exp_addr] <= Exp_mask;
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         len_r          <= '0;
         n_cmp          <= '0;
         stall          <= '0;
         prev_pc        <= '0;
         have_prev      <= 1'b0;
         have_fail      <= 1'b0;
         pass_r         <= 1'b0;
         Halt_detected  <= 1'b0;
         Mismatch_count <= '0;
         First_fail_idx <= '0;
         First_fail_ch  <= '0;
      end else if (Start) begin
         len_r          <= len_c;
         n_cmp          <= '0;
         stall          <= '0;
         have_prev      <= 1'b0;
         have_fail      <= 1'b0;
         pass_r         <= len_c == '0;
         Halt_detected  <= 1'b0;
         Mismatch_count <= '0;
         First_fail_idx <= '0;
         First_fail_ch  <= '0;
      end else if (sample_ev) begin
         n_cmp     <= cmp_nxt;
         stall     <= stall_nxt;
         prev_pc   <= pc;
         have_prev <= 1'b1;
         if (mism) begin
            if (Mismatch_count != 16'hFFFF)
               Mismatch_count <= Mismatch_count + 16'd1;
            if (!have_fail) begin
               have_fail      <= 1'b1;
               First_fail_idx <= n_cmp[AW-1:0];
               First_fail_ch  <= fch;
            end
         end
         if (halt_fire) Halt_detected <= 1'b1;
         // An early halt leaves compared < length, so it can only pass
         // when it lands on the final entry.
         if (last || halt_fire)
            pass_r <= last && !mism && Mismatch_count == 16'd0;
      end
   end

   assign Busy = state == RUN;
   assign Done = state == DONE;
   assign Pass = Done && pass_r;

endmodule

// File: tb/tb_datapath_trace_checker.sv
// tb_datapath_trace_checker: directed scenarios for the trace checker.
// Inputs change on the falling edge; outputs are checked #1 after rising.
module tb_datapath_trace_checker;

   localparam int WIDTH = 32;
   localparam int NUM_CH = 4;
   localparam int DEPTH = 256;
   localparam int AW = 8;

   logic                    Clk = 1'b0;
   logic                    Rst;
   logic                    Start;
   logic [AW:0]             Trace_len;
   logic                    Exp_we;
   logic [AW-1:0]           Exp_addr;
   logic [NUM_CH*WIDTH-1:0] Exp_data;
`ifdef TRACE_MASK_EN
   logic [NUM_CH-1:0]       Exp_mask;
`endif
   logic                    Obs_valid;
   logic [NUM_CH*WIDTH-1:0] Obs_data;
   logic                    Busy;
   logic                    Done;
   logic                    Pass;
   logic                    Halt_detected;
   logic [15:0]             Mismatch_count;
   logic [AW-1:0]           First_fail_idx;
   logic [1:0]              First_fail_ch;

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   datapath_trace_checker #(
      .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH),
      .PC_CH(1), .HALT_CYCLES(8)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Trace_len(Trace_len),
      .Exp_we(Exp_we), .Exp_addr(Exp_addr), .Exp_data(Exp_data),
`ifdef TRACE_MASK_EN
      .Exp_mask(Exp_mask),
`endif
      .Obs_valid(Obs_valid), .Obs_data(Obs_data),
      .Busy(Busy), .Done(Done), .Pass(Pass),
      .Halt_detected(Halt_detected), .Mismatch_count(Mismatch_count),
      .First_fail_idx(First_fail_idx), .First_fail_ch(First_fail_ch)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      Rst = 1'b0; Start = 1'b0; Exp_we = 1'b0; Obs_valid = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input int a, input logic [31:0] d0, d1, d2, d3,
                     input logic [3:0] m);
      @(negedge Clk);
      idle_inputs();
      Exp_we = 1'b1; Exp_addr = AW'(a); Exp_data = {d3, d2, d1, d0};
`ifdef TRACE_MASK_EN
      Exp_mask = m;
`else
      if (m == 4'hx) Exp_we = 1'b0;
`endif
      step();
      Exp_we = 1'b0;
   endtask

   task automatic smp(input logic v, input logic [31:0] d0, d1, d2, d3);
      @(negedge Clk);
      idle_inputs();
      Obs_valid = v; Obs_data = {d3, d2, d1, d0};
      step();
   endtask

   task automatic start_run(input int len);
      @(negedge Clk);
      idle_inputs();
      Start = 1'b1; Trace_len = (AW+1)'(len);
      step();
      Start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      idle_inputs();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
   endtask

   function automatic logic [31:0] hpc(input int i);
      return (i == 0) ? 32'h0 : (i == 1) ? 32'h4 : 32'h20;
   endfunction

   task automatic test_reset();
      do_reset();
      chk("rst_busy", {31'b0, Busy}, 0);
      chk("rst_done", {31'b0, Done}, 0);
      chk("rst_pass", {31'b0, Pass}, 0);
      chk("rst_halt", {31'b0, Halt_detected}, 0);
      chk("rst_cnt", {16'b0, Mismatch_count}, 0);
      chk("rst_ffi", {24'b0, First_fail_idx}, 0);
      chk("rst_ffc", {30'b0, First_fail_ch}, 0);
   endtask

   task automatic test_pass();
      for (int i = 0; i < 4; i++) wr(i, 0, 32'(i * 4), 0, 0, 4'hF);
      start_run(4);
      chk("pass_busy", {31'b0, Busy}, 1);
      for (int i = 0; i < 4; i++) begin
         smp(1, 0, 32'(i * 4), 0, 0);
         if (i == 2) chk("pass_early_done", {31'b0, Done}, 0);
      end
      chk("pass_done", {31'b0, Done}, 1);
      chk("pass_busy_end", {31'b0, Busy}, 0);
      chk("pass_pass", {31'b0, Pass}, 1);
      chk("pass_cnt", {16'b0, Mismatch_count}, 0);
      chk("pass_halt", {31'b0, Halt_detected}, 0);
   endtask

   task automatic test_mismatch();
      start_run(4);
      smp(1, 0, 32'h0, 0, 0);
      smp(1, 0, 32'h4, 0, 0);
      smp(1, 0, 32'h8, 32'h5, 0);
      chk("mm_cnt_lat", {16'b0, Mismatch_count}, 1);
      chk("mm_ffi_lat", {24'b0, First_fail_idx}, 2);
      smp(1, 32'h77, 32'hC, 0, 0);
      chk("mm_done", {31'b0, Done}, 1);
      chk("mm_cnt", {16'b0, Mismatch_count}, 2);
      chk("mm_ffi", {24'b0, First_fail_idx}, 2);
      chk("mm_ffc", {30'b0, First_fail_ch}, 2);
      chk("mm_pass", {31'b0, Pass}, 0);
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 0; i < 20; i++) wr(i, 0, hpc(i), 0, 0, 4'hF);
      start_run(20);
      for (int i = 0; i < 10; i++) begin
         smp(1, 0, hpc(i), 0, 0);
         if (i == 8) chk("halt_early", {31'b0, Done}, 0);
      end
      chk("halt_done", {31'b0, Done}, 1);
      chk("halt_flag", {31'b0, Halt_detected}, 1);
      chk("halt_pass", {31'b0, Pass}, 0);
      chk("halt_cnt", {16'b0, Mismatch_count}, 0);
   endtask

   task automatic test_valid_gap();
      start_run(20);
      smp(1, 0, 32'h0, 0, 0);
      smp(1, 0, 32'h4, 0, 0);
      smp(1, 0, 32'h20, 0, 0);
      smp(0, 32'hDEAD, 32'h20, 0, 0);
      smp(0, 32'hDEAD, 32'h20, 0, 0);
      smp(1, 0, 32'h20, 0, 0);
      smp(1, 32'hBAD, 32'h20, 0, 0);
      chk("gap_cnt", {16'b0, Mismatch_count}, 1);
      chk("gap_ffi", {24'b0, First_fail_idx}, 4);
      chk("gap_ffc", {30'b0, First_fail_ch}, 0);
      for (int i = 5; i < 10; i++) begin
         smp(1, 0, 32'h20, 0, 0);
         if (i == 8) chk("gap_no_halt", {31'b0, Done}, 0);
      end
      chk("gap_halt", {31'b0, Halt_detected}, 1);
   endtask

   task automatic test_rst_midrun();
      start_run(6);
      for (int i = 0; i < 3; i++) smp(1, 0, hpc(i), 0, 0);
      @(negedge Clk);
      idle_inputs();
      Exp_we = 1'b1; Exp_addr = 3; Exp_data = '1;
`ifdef TRACE_MASK_EN
      Exp_mask = 4'hF;
`endif
      step();
      for (int i = 3; i < 5; i++) smp(1, 0, hpc(i), 0, 0);
      chk("we_ignored", {16'b0, Mismatch_count}, 0);
      @(negedge Clk);
      idle_inputs();
      Rst = 1'b1; Obs_valid = 1'b1; Obs_data = {64'h0, 32'h20, 32'h1};
      step();
      chk("mid_busy", {31'b0, Busy}, 0);
      chk("mid_done", {31'b0, Done}, 0);
      chk("mid_cnt", {16'b0, Mismatch_count}, 0);
      @(negedge Clk);
      idle_inputs();
      Rst = 1'b1; Start = 1'b1; Trace_len = 6;
      step();
      chk("rst_dom_start", {31'b0, Busy}, 0);
      start_run(6);
      for (int i = 0; i < 6; i++) smp(1, 0, hpc(i), 0, 0);
      chk("rerun_done", {31'b0, Done}, 1);
      chk("rerun_pass", {31'b0, Pass}, 1);
   endtask

   task automatic test_zero_len();
      start_run(0);
      chk("zero_done", {31'b0, Done}, 1);
      chk("zero_pass", {31'b0, Pass}, 1);
      chk("zero_busy", {31'b0, Busy}, 0);
   endtask

   task automatic test_clamp();
      start_run(9'h1FF);
      for (int i = 0; i < 256; i++) begin
         smp(1, 0, 32'(i * 4 + 1), 0, 0);
         if (i == 254) chk("clamp_early", {31'b0, Done}, 0);
      end
      chk("clamp_done", {31'b0, Done}, 1);
      chk("clamp_halt", {31'b0, Halt_detected}, 0);
   endtask

`ifdef TRACE_MASK_EN
   task automatic test_mask();
      do_reset();
      wr(0, 0, 32'h0, 0, 0, 4'hF);
      wr(1, 0, 32'h4, 0, 0, 4'b1101);
      start_run(2);
      smp(1, 0, 32'h0, 0, 0);
      smp(1, 0, 32'h99, 0, 0);
      chk("mask_pass", {31'b0, Pass}, 1);
      do_reset();
      wr(1, 0, 32'h4, 0, 0, 4'hF);
      start_run(2);
      smp(1, 0, 32'h0, 0, 0);
      smp(1, 0, 32'h99, 0, 0);
      chk("mask_ffc", {30'b0, First_fail_ch}, 1);
      chk("mask_fail", {31'b0, Pass}, 0);
   endtask
`endif

   initial begin
      idle_inputs();
      Trace_len = '0; Exp_addr = '0; Exp_data = '0; Obs_data = '0;
`ifdef TRACE_MASK_EN
      Exp_mask = '1;
`endif
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      test_reset();
      test_pass();
      test_mismatch();
      test_halt();
      test_valid_gap();
      test_rst_midrun();
      test_zero_len();
      test_clamp();
`ifdef TRACE_MASK_EN
      test_mask();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
